// File: rtl/gpio_ahb_arbiter.sv
// Two-requester round-robin AHB-lite master feeding the GPIO slave port.
// Optional data-phase wait-state timeout: define GPIO_ARB_TIMEOUT_EN.
module gpio_ahb_arbiter #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [1:0]             REQ,
  input  logic [1:0]             WE,
  input  logic [1:0][DATA_W-1:0] ADDR,
  input  logic [1:0][DATA_W-1:0] WDATA,
  output logic [1:0]             DONE,
  output logic [1:0]             ERR,
  output logic [DATA_W-1:0]      RDATA,
  output logic [DATA_W-1:0]      HADDR,
  output logic [1:0]             HTRANS,
  output logic                   HWRITE,
  output logic [DATA_W-1:0]      HWDATA,
  output logic                   HSEL,
  output logic                   HREADY,
  input  logic                   HREADYOUT,
  input  logic [DATA_W-1:0]      HRDATA
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  state_t              state, state_n;
  logic [1:0]          req_m;
  logic                win;
  logic                owner;
  logic                last_owner;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                tmo;

  assign HREADY = HREADYOUT;

  // A requester is ignored while its DONE pulse is out, so a held REQ is not re-granted.
  always_comb begin
    req_m = REQ & ~DONE;
    win   = (req_m == 2'b11) ? ~last_owner : req_m[1];
  end

`ifdef GPIO_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] wcnt;
  logic [1:0]    err_q;

  assign tmo = (state == ST_DATA) && !HREADYOUT && (wcnt == TMO_LAST);
  assign ERR = err_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wcnt  <= '0;
      err_q <= '0;
    end else begin
      err_q <= '0;
      if (state == ST_ADDR) begin
        wcnt <= '0;
      end else if (state == ST_DATA && !HREADYOUT) begin
        wcnt <= wcnt + 1'b1;
      end
      if (tmo) begin
        err_q[owner] <= 1'b1;
      end
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign tmo        = 1'b0;
  assign ERR        = '0;
`endif

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (|req_m) state_n = ST_ADDR;
      ST_ADDR: state_n = ST_DATA;
      ST_DATA: if (HREADYOUT || tmo) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Grant latch, bus phases and completion; every output here is registered.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      owner      <= 1'b0;
      last_owner <= 1'b1;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      HADDR      <= '0;
      HTRANS     <= 2'b00;
      HWRITE     <= 1'b0;
      HWDATA     <= '0;
      HSEL       <= 1'b0;
      DONE       <= '0;
      RDATA      <= '0;
    end else begin
      DONE <= '0;
      case (state)
        ST_IDLE: begin
          if (|req_m) begin
            owner   <= win;
            we_q    <= WE[win];
            wdata_q <= WDATA[win];
            HADDR   <= ADDR[win];
            HWRITE  <= WE[win];
            HSEL    <= 1'b1;
            HTRANS  <= 2'b10;
          end
        end
        ST_ADDR: begin
          HSEL   <= 1'b0;
          HTRANS <= 2'b00;
          HWDATA <= we_q ? wdata_q : '0;
        end
        ST_DATA: begin
          if (HREADYOUT) begin
            if (!we_q) begin
              RDATA <= HRDATA;
            end
            DONE[owner] <= 1'b1;
            last_owner  <= owner;
          end else if (tmo) begin
            DONE[owner] <= 1'b1;
            last_owner  <= owner;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_ahb_arbiter.sv
// Scoreboard bench for gpio_ahb_arbiter: random requester traffic, memory-backed slave model.
module tb_gpio_ahb_arbiter;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic                HCLK = 1'b0;
  logic                HRESET;
  logic [1:0]          REQ, WE, DONE, ERR;
  logic [1:0][DW-1:0]  ADDR, WDATA;
  logic [DW-1:0]       RDATA, HADDR, HWDATA, HRDATA;
  logic [1:0]          HTRANS;
  logic                HWRITE, HSEL, HREADY, HREADYOUT;

  gpio_ahb_arbiter #(.DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
    .DONE(DONE), .ERR(ERR), .RDATA(RDATA), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HSEL(HSEL), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA)
  );

  always #5 HCLK = ~HCLK;

  typedef struct { bit we; logic [DW-1:0] a; logic [DW-1:0] d; } tx_t;
  typedef struct { int owner; bit err; logic [DW-1:0] rd; } exp_t;

  tx_t           txq0[$], txq1[$];
  exp_t          exp_q[$];
  int            wq[$];
  logic [DW-1:0] ref_mem[logic [DW-1:0]];
  logic [DW-1:0] slv_mem[logic [DW-1:0]];
  int            last_owner = 1;
  logic [DW-1:0] last_rdata = '0;
  int            n_checks = 0;
  int            n_err = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  function automatic logic [DW-1:0] dflt(input logic [DW-1:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [DW-1:0] raddr();
    logic [DW-1:0] a;
    a = '0;
    a[4:2] = 3'($urandom_range(0, 7));
    return a;
  endfunction

  // Reference: one expected completion per issued transfer, in predicted grant order.
  task automatic model_issue(input int i, input bit we, input logic [DW-1:0] a,
                             input logic [DW-1:0] d, input int waits, input bit tmo);
    exp_t e;
    e.owner = i;
    e.err   = tmo;
    if (tmo || we) begin
      e.rd = last_rdata;
    end else begin
      e.rd = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
      last_rdata = e.rd;
    end
    if (we && !tmo) ref_mem[a] = d;
    last_owner = i;
    exp_q.push_back(e);
    wq.push_back(waits);
  endtask

  task automatic push_tx(input int i, input bit we, input logic [DW-1:0] a, input logic [DW-1:0] d);
    tx_t t;
    t.we = we; t.a = a; t.d = d;
    if (i == 0) txq0.push_back(t);
    else        txq1.push_back(t);
  endtask

  // Requester drivers: hold REQ until DONE, then move to the next queued transfer.
  initial begin
    bit [1:0] cur;
    tx_t      t;
    cur = '0; REQ = '0; WE = '0; ADDR = '0; WDATA = '0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        cur = '0;
        REQ = '0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (DONE[i]) cur[i] = 1'b0;
          if (!cur[i]) begin
            if (i == 0 && txq0.size() > 0) begin
              t = txq0.pop_front(); cur[i] = 1'b1;
              WE[i] = t.we; ADDR[i] = t.a; WDATA[i] = t.d;
            end else if (i == 1 && txq1.size() > 0) begin
              t = txq1.pop_front(); cur[i] = 1'b1;
              WE[i] = t.we; ADDR[i] = t.a; WDATA[i] = t.d;
            end
          end
          REQ[i] = cur[i];
        end
      end
    end
  end

  // GPIO slave model with per-transfer wait states taken from wq.
  initial begin
    bit            pend, s_w;
    int            s_wc;
    logic [DW-1:0] s_a;
    pend = 0; s_w = 0; s_wc = 0; s_a = '0;
    HREADYOUT = 1'b1; HRDATA = '0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        pend = 0;
        HREADYOUT = 1'b1;
      end else if (HSEL && HTRANS == 2'b10) begin
        s_a = HADDR; s_w = HWRITE;
        s_wc = (wq.size() > 0) ? wq.pop_front() : 0;
        pend = 1; HREADYOUT = 1'b1;
      end else if (pend) begin
        if (s_wc > 0) begin
          s_wc--; HREADYOUT = 1'b0; HRDATA = $urandom;
        end else begin
          pend = 0; HREADYOUT = 1'b1;
          if (s_w) slv_mem[s_a] = HWDATA;
          else     HRDATA = slv_mem.exists(s_a) ? slv_mem[s_a] : dflt(s_a);
        end
      end else begin
        HREADYOUT = 1'b1; HRDATA = $urandom;
      end
    end
  end

  // Monitor: every DONE pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      #1;
      if (!HRESET) begin
        chk("hready_copy", {31'b0, HREADY}, {31'b0, HREADYOUT});
        if (DONE != 2'b00) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", {30'b0, DONE}, '0);
          end else begin
            e = exp_q.pop_front();
            chk("done_owner", {30'b0, DONE}, 32'(1 << e.owner));
            chk("done_err", {30'b0, ERR}, e.err ? 32'(1 << e.owner) : 32'd0);
            chk("rdata", RDATA, e.rd);
          end
        end
      end
    end
  end

  task automatic single(input int i, input bit we, input logic [DW-1:0] a,
                        input logic [DW-1:0] d, input int waits, input bit tmo);
    int k;
    int lat;
    model_issue(i, we, a, d, waits, tmo);
    lat = tmo ? (2 + TMO) : (3 + waits);
    @(posedge HCLK); #1;
    push_tx(i, we, a, d);
    @(negedge HCLK);
    @(posedge HCLK);
    @(negedge HCLK);
    chk("aph_hsel", {31'b0, HSEL}, 32'd1);
    chk("aph_htrans", {30'b0, HTRANS}, 32'd2);
    chk("aph_haddr", HADDR, a);
    chk("aph_hwrite", {31'b0, HWRITE}, {31'b0, we});
    @(negedge HCLK);
    chk("dph_hsel", {31'b0, HSEL}, 32'd0);
    chk("dph_htrans", {30'b0, HTRANS}, 32'd0);
    chk("dph_hwdata", HWDATA, we ? d : '0);
    k = 2;
    while (!DONE[i] && k < 200) begin
      @(negedge HCLK);
      k++;
    end
    chk("latency", 32'(k), 32'(lat));
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      @(negedge HCLK);
      k++;
    end
    if (exp_q.size() != 0) begin
      fail("drain_timeout");
      exp_q.delete();
    end
    repeat (2) @(negedge HCLK);
  endtask

  // Both requesters pending throughout: grants must alternate starting opposite the last owner.
  task automatic both(input int n);
    int            w;
    bit            we;
    logic [DW-1:0] a, d;
    @(posedge HCLK); #1;
    w = 1 - last_owner;
    for (int k = 0; k < 2 * n; k++) begin
      we = 1'($urandom_range(0, 1));
      a  = raddr();
      d  = $urandom;
      model_issue(w, we, a, d, $urandom_range(0, 2), 1'b0);
      push_tx(w, we, a, d);
      w = 1 - w;
    end
    drain(60 * n);
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    exp_q.delete(); wq.delete(); txq0.delete(); txq1.delete();
    last_owner = 1; last_rdata = '0;
    repeat (3) @(negedge HCLK);
    #1 HRESET = 1'b0;
  endtask

  initial begin
    int seen;
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    HRESET = 1'b1;
    ref_mem[32'h0] = 32'h0000_1234;
    slv_mem[32'h0] = 32'h0000_1234;
    #12;
    chk("rst_haddr", HADDR, '0);
    chk("rst_htrans", {30'b0, HTRANS}, '0);
    chk("rst_hwrite", {31'b0, HWRITE}, '0);
    chk("rst_hwdata", HWDATA, '0);
    chk("rst_hsel", {31'b0, HSEL}, '0);
    chk("rst_done", {30'b0, DONE}, '0);
    chk("rst_err", {30'b0, ERR}, '0);
    chk("rst_rdata", RDATA, '0);
    @(negedge HCLK); #1 HRESET = 1'b0;

    both(2);
    single(0, 1'b1, 32'h4, 32'h0000_A5A5, 0, 1'b0);
    single(1, 1'b0, 32'h0, 32'h0, 2, 1'b0);
    drain(20);

    for (int r = 0; r < 16; r++) begin
      single($urandom_range(0, 1), 1'($urandom_range(0, 1)), raddr(), $urandom,
             $urandom_range(0, 3), 1'b0);
    end
    drain(20);
    for (int r = 0; r < 3; r++) both($urandom_range(1, 3));

    // Reset in the middle of a req0 read data phase.
    @(posedge HCLK); #1;
    wq.push_back(6);
    push_tx(0, 1'b0, 32'h8, 32'h0);
    @(negedge HCLK);
    @(posedge HCLK);
    @(negedge HCLK);
    @(negedge HCLK);
    #1 HRESET = 1'b1;
    #1;
    chk("midrst_hsel", {31'b0, HSEL}, '0);
    chk("midrst_htrans", {30'b0, HTRANS}, '0);
    chk("midrst_haddr", HADDR, '0);
    chk("midrst_rdata", RDATA, '0);
    chk("midrst_hwdata", HWDATA, '0);
    do_reset();
    seen = 0;
    repeat (10) begin
      @(negedge HCLK);
      if (DONE != 2'b00) seen = 1;
    end
    chk("midrst_no_done", 32'(seen), '0);
    both(1);

`ifdef GPIO_ARB_TIMEOUT_EN
    single(0, 1'b0, 32'hC, 32'h0, 1000, 1'b1);
    drain(20);
    single(1, 1'b0, 32'h10, 32'h0, 1, 1'b0);
    drain(20);
`else
    @(posedge HCLK); #1;
    wq.push_back(1000);
    push_tx(0, 1'b0, 32'hC, 32'h0);
    seen = 0;
    repeat (105) begin
      @(negedge HCLK);
      if (DONE != 2'b00) seen = 1;
    end
    chk("stall_no_done", 32'(seen), '0);
    do_reset();
    single(1, 1'b0, 32'h10, 32'h0, 1, 1'b0);
    drain(20);
`endif

    repeat (3) @(negedge HCLK);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
